// File: rtl/cpu_isa_pkg.sv
// Shared ISA definitions for the fetch/decode front end:
// opcodes, field positions, halt word, FSM encoding, decoded bundle.
package cpu_isa_pkg;

    localparam logic [3:0] OP_ADD    = 4'b0010;
    localparam logic [3:0] OP_SHIFTL = 4'b0100;
    localparam logic [3:0] OP_ADDI   = 4'b1100;
    localparam logic [3:0] OP_SUBI   = 4'b1111;

    localparam int OPC_MSB = 31;
    localparam int OPC_LSB = 28;
    localparam int DST_MSB = 27;
    localparam int DST_LSB = 23;
    localparam int S1_MSB  = 22;
    localparam int S1_LSB  = 18;
    localparam int S2_MSB  = 17;
    localparam int S2_LSB  = 13;
    localparam int IMM_MSB = 17;
    localparam int IMM_LSB = 0;

    localparam logic [31:0] HALT_WORD = 32'd0;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_HALTED = 2'b10
    } fsm_state_t;

    typedef struct packed {
        logic [3:0]  opcode;
        logic [4:0]  dest;
        logic [4:0]  src1;
        logic [4:0]  src2;
        logic [17:0] imm;
        logic        is_itype;
    } dec_fields_t;

endpackage

// File: rtl/instr_fetch_decode_if.sv
// Fetch/decode bus: ROM address/data, branch redirect,
// and the valid/ready decoded-instruction channel to execute.
interface instr_fetch_decode_if #(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_data;
    logic               redir_valid;
    logic [ADDR_W-1:0]  redir_addr;
    logic               dec_valid;
    logic               dec_ready;
    logic [3:0]         dec_opcode;
    logic [4:0]         dec_dest;
    logic [4:0]         dec_src1;
    logic [4:0]         dec_src2;
    logic [17:0]        dec_imm;
    logic               dec_is_itype;
    logic [ADDR_W-1:0]  dec_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        input  redir_valid,
        input  redir_addr,
        output dec_valid,
        input  dec_ready,
        output dec_opcode,
        output dec_dest,
        output dec_src1,
        output dec_src2,
        output dec_imm,
        output dec_is_itype,
        output dec_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        output redir_valid,
        output redir_addr,
        input  dec_valid,
        output dec_ready,
        input  dec_opcode,
        input  dec_dest,
        input  dec_src1,
        input  dec_src2,
        input  dec_imm,
        input  dec_is_itype,
        input  dec_pc
    );

endinterface

// File: rtl/instr_field_decode.sv
// Pure combinational split of a 32-bit instruction word into fields.
// Reused by trace/disassembly logic, so it carries no state.
module instr_field_decode
    import cpu_isa_pkg::*;
(
    input  logic [31:0] i_word,
    output dec_fields_t o_fields
);

    // Slice the fixed field layout; I-type is opcode[3:2]==2'b11
    always_comb begin
        o_fields          = '0;
        o_fields.opcode   = i_word[OPC_MSB:OPC_LSB];
        o_fields.dest     = i_word[DST_MSB:DST_LSB];
        o_fields.src1     = i_word[S1_MSB:S1_LSB];
        o_fields.src2     = i_word[S2_MSB:S2_LSB];
        o_fields.imm      = i_word[IMM_MSB:IMM_LSB];
        o_fields.is_itype = (i_word[OPC_MSB:OPC_MSB-1] == OP_ADDI[3:2]);
    end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns the PC, reads the combinational ROM,
// registers one decoded instruction per cycle behind a valid/ready handshake.
module instr_fetch_decode
    import cpu_isa_pkg::*;
#(
    parameter int ADDR_W  = 5,
    parameter int INSTR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    instr_fetch_decode_if.master bus,
    output logic              halted,
    output logic [ADDR_W:0]   insn_count
);

    fsm_state_t        r_state;
    fsm_state_t        w_state_n;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] w_pc_n;
    dec_fields_t       r_fld;
    dec_fields_t       w_fld_n;
    dec_fields_t       w_fld;
    logic              r_dec_valid;
    logic              w_dec_valid_n;
    logic [ADDR_W-1:0] r_dec_pc;
    logic [ADDR_W-1:0] w_dec_pc_n;
    logic [ADDR_W:0]   r_count;
    logic [ADDR_W:0]   w_count_n;

    logic [INSTR_W-1:0] w_word;
    logic               w_load;
    logic               w_xfer;
    logic               w_nonzero;
    logic               w_last;

    assign w_word    = bus.imem_data;
    assign w_load    = !r_dec_valid || bus.dec_ready;
    assign w_xfer    = r_dec_valid && bus.dec_ready;
    assign w_nonzero = (w_word != HALT_WORD);
    assign w_last    = (r_pc == {ADDR_W{1'b1}});

    instr_field_decode u_dec (
        .i_word   (w_word),
        .o_fields (w_fld)
    );

    // Next state and next datapath values; everything holds by default
    always_comb begin
        w_state_n     = r_state;
        w_pc_n        = r_pc;
        w_fld_n       = r_fld;
        w_dec_valid_n = r_dec_valid;
        w_dec_pc_n    = r_dec_pc;
        w_count_n     = r_count;

        if (w_xfer && (r_count != {(ADDR_W+1){1'b1}})) begin
            w_count_n = r_count + 1'b1;
        end

        unique case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_n = ST_RUN;
                    w_pc_n    = '0;
                    w_count_n = '0;
                end
            end
            ST_RUN: begin
                if (bus.redir_valid) begin
                    w_dec_valid_n = 1'b0;
                    w_pc_n        = bus.redir_addr;
                end else if (w_load) begin
                    if (w_nonzero) begin
                        w_fld_n       = w_fld;
                        w_dec_pc_n    = r_pc;
                        w_dec_valid_n = 1'b1;
                        if (w_last) begin
                            w_state_n = ST_HALTED;
                        end else begin
                            w_pc_n = r_pc + 1'b1;
                        end
                    end else begin
                        w_dec_valid_n = 1'b0;
                        w_state_n     = ST_HALTED;
                    end
                end
            end
            ST_HALTED: begin
                if (w_xfer) begin
                    w_dec_valid_n = 1'b0;
                end
                if (start && !r_dec_valid) begin
                    w_state_n = ST_RUN;
                    w_pc_n    = '0;
                    w_count_n = '0;
                end
            end
            default: begin
                w_state_n = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_n;
        end
    end

    // PC, decoded output register and transfer counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc        <= '0;
            r_fld       <= '0;
            r_dec_valid <= 1'b0;
            r_dec_pc    <= '0;
            r_count     <= '0;
        end else begin
            r_pc        <= w_pc_n;
            r_fld       <= w_fld_n;
            r_dec_valid <= w_dec_valid_n;
            r_dec_pc    <= w_dec_pc_n;
            r_count     <= w_count_n;
        end
    end

    assign bus.imem_addr    = r_pc;
    assign bus.dec_valid    = r_dec_valid;
    assign bus.dec_opcode   = r_fld.opcode;
    assign bus.dec_dest     = r_fld.dest;
    assign bus.dec_src1     = r_fld.src1;
    assign bus.dec_src2     = r_fld.src2;
    assign bus.dec_imm      = r_fld.imm;
    assign bus.dec_is_itype = r_fld.is_itype;
    assign bus.dec_pc       = r_dec_pc;
    assign halted           = (r_state == ST_HALTED);
    assign insn_count       = r_count;

endmodule
